// File: rtl/side_pkg.sv
// Shared constants for the switch-side egress path: lane count, defaults, lane FSM encodings.
package side_pkg;

  localparam int unsigned AW_DEV = 2;
  localparam int unsigned N_DEV  = 1 << AW_DEV;

  // Defaults shared by the side and port blocks.
  localparam int unsigned DW_DEF    = 4;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned SLACK_DEF = 2;

  // Lane transmitter states (kept as plain constants for legacy compatibility).
  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StSend    = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

endpackage

// File: rtl/egress_lane.sv
// One egress lane: FIFO, occupancy count, almost-full/overflow flags and a four-phase
// validrx/ackrx transmitter toward the attached device.
module egress_lane
  import side_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned SLACK = SLACK_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wen_i,
  input  logic [DW-1:0] dat_i,
  output logic          full_o,
  output logic          ovf_o,
  output logic [DW-1:0] dat_o,
  output logic          validrx,
  input  logic          ackrx
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    state_q, state_d;
  logic          full_q, full_d;
  logic          ovf_q;
  logic [DW-1:0] dat_q;
  logic          valid_q, valid_d;
  logic          push, pop;

  // Push only with room; pop whenever the transmitter is idle and data is waiting.
  always_comb begin
    push  = wen_i && (cnt_q < CW'(DEPTH));
    pop   = (state_q == StIdle) && (cnt_q != '0);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    // Upstream has SLACK writes in flight after it sees full, so flag early.
    full_d = (32'(cnt_d) + SLACK) >= DEPTH;
  end

  // Lane FSM next-state and validrx next value.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StSend;
          valid_d = 1'b1;
        end
      end
      StSend: begin
        if (ackrx) begin
          state_d = StRelease;
          valid_d = 1'b0;
        end
      end
      StRelease: begin
        if (!ackrx) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  // FIFO storage; contents need no reset since the count gates all reads.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= dat_i;
  end

  // Pointers, count, flags, FSM and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      state_q <= StIdle;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dat_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      full_q  <= full_d;
      valid_q <= valid_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
        dat_q  <= mem_q[rptr_q];
      end
      if (wen_i && !push) ovf_q <= 1'b1;
    end
  end

  assign full_o  = full_q;
  assign ovf_o   = ovf_q;
  assign dat_o   = dat_q;
  assign validrx = valid_q;

endmodule

// File: rtl/side_egress.sv
// Receiving end of the switch-side internal write bus: one independent egress lane per device.
module side_egress
  import side_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned SLACK = SLACK_DEF,
  parameter int unsigned N     = N_DEV
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    int_wen_i,
  input  logic [DW-1:0]   int_dat_i,
  output logic [N-1:0]    full_o,
  output logic [N-1:0]    ovf_o,
  output logic [N*DW-1:0] dat_o,
  output logic [N-1:0]    validrx,
  input  logic [N-1:0]    ackrx
);

  // Data bus is shared; multiple wen bits write every flagged lane (broadcast).
  for (genvar k = 0; k < N; k++) begin : g_lane
    egress_lane #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .SLACK (SLACK)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .wen_i   (int_wen_i[k]),
      .dat_i   (int_dat_i),
      .full_o  (full_o[k]),
      .ovf_o   (ovf_o[k]),
      .dat_o   (dat_o[k*DW +: DW]),
      .validrx (validrx[k]),
      .ackrx   (ackrx[k])
    );
  end

endmodule

// File: tb/tb_side_egress.sv
// Directed self-checking bench for side_egress.
module tb_side_egress;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [3:0]  int_wen_i = '0;
  logic [3:0]  int_dat_i = '0;
  logic [3:0]  full_o;
  logic [3:0]  ovf_o;
  logic [15:0] dat_o;
  logic [3:0]  validrx;
  logic [3:0]  ackrx = '0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  side_egress u_dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .int_wen_i (int_wen_i),
    .int_dat_i (int_dat_i),
    .full_o    (full_o),
    .ovf_o     (ovf_o),
    .dat_o     (dat_o),
    .validrx   (validrx),
    .ackrx     (ackrx)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Full four-phase ack on one lane, then one more edge for the next pop.
  task automatic handshake(input int lane);
    ackrx[lane] = 1'b1;
    tick();
    ackrx[lane] = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_valid", 32'(validrx), 32'h0);
    check("rst_dat", 32'(dat_o), 32'h0);
    check("rst_full", 32'(full_o), 32'h0);
    check("rst_ovf", 32'(ovf_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Single write to lane 1
    int_wen_i = 4'b0010;
    int_dat_i = 4'hA;
    tick();
    int_wen_i = '0;
    check("t1_not_yet", 32'(validrx), 32'h0);
    tick();
    check("t1_valid", 32'(validrx), 32'b0010);
    check("t1_dat", 32'(dat_o), 32'h00A0);
    ackrx[1] = 1'b1;
    tick();
    check("t1_valid_drop", 32'(validrx), 32'h0);
    ackrx[1] = 1'b0;
    tick();
    check("t1_full", 32'(full_o), 32'h0);
    tick();
    check("t1_idle", 32'(validrx), 32'h0);

    // Lane 0 burst with ack held low: fill, almost-full, overflow
    for (int i = 1; i <= 6; i++) begin
      int_wen_i = 4'b0001;
      int_dat_i = 4'(i);
      tick();
      if (i == 1) check("t2_full_p1", 32'(full_o[0]), 32'h0);
      if (i == 2) begin
        check("t2_valid_p2", 32'(validrx[0]), 32'h1);
        check("t2_dat_p2", 32'(dat_o[3:0]), 32'h1);
        check("t2_full_p2", 32'(full_o[0]), 32'h0);
      end
      if (i == 3) check("t2_full_p3", 32'(full_o[0]), 32'h1);
      if (i == 5) check("t2_ovf_p5", 32'(ovf_o[0]), 32'h0);
      if (i == 6) check("t2_ovf_p6", 32'(ovf_o[0]), 32'h1);
    end
    int_wen_i = '0;
    for (int w = 1; w <= 5; w++) begin
      check("t2_drain_valid", 32'(validrx[0]), 32'h1);
      check("t2_drain_dat", 32'(dat_o[3:0]), 32'(w));
      handshake(0);
    end
    check("t2_empty", 32'(validrx[0]), 32'h0);
    check("t2_full_end", 32'(full_o[0]), 32'h0);
    check("t2_ovf_sticky", 32'(ovf_o[0]), 32'h1);

    // Broadcast
    int_wen_i = 4'b1111;
    int_dat_i = 4'h7;
    tick();
    int_wen_i = '0;
    tick();
    check("t3_valid", 32'(validrx), 32'b1111);
    check("t3_dat", 32'(dat_o), 32'h7777);
    ackrx = 4'b0100;
    tick();
    check("t3_ack2", 32'(validrx), 32'b1011);
    ackrx = '0;
    tick();
    check("t3_others", 32'(validrx), 32'b1011);
    check("t3_dat_hold", 32'(dat_o), 32'h7777);
    ackrx = 4'b1011;
    tick();
    ackrx = '0;
    tick();
    check("t3_all_done", 32'(validrx), 32'h0);

    // Lane 3: push while idle with count 1, pop and push in the same edge
    int_wen_i = 4'b1000;
    int_dat_i = 4'h8;
    tick();
    int_dat_i = 4'h9;
    tick();
    int_wen_i = '0;
    check("t4_valid", 32'(validrx[3]), 32'h1);
    check("t4_dat8", 32'(dat_o[15:12]), 32'h8);
    check("t4_full", 32'(full_o[3]), 32'h0);
    handshake(3);
    check("t4_valid9", 32'(validrx[3]), 32'h1);
    check("t4_dat9", 32'(dat_o[15:12]), 32'h9);
    handshake(3);
    check("t4_empty", 32'(validrx[3]), 32'h0);

    // Asynchronous reset mid-handshake with a word still queued
    int_wen_i = 4'b0001;
    int_dat_i = 4'h5;
    tick();
    int_dat_i = 4'h6;
    tick();
    int_wen_i = '0;
    check("t5_pre_valid", 32'(validrx[0]), 32'h1);
    check("t5_pre_dat", 32'(dat_o[3:0]), 32'h5);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t5_async_valid", 32'(validrx), 32'h0);
    check("t5_async_dat", 32'(dat_o), 32'h0);
    check("t5_async_full", 32'(full_o), 32'h0);
    check("t5_async_ovf", 32'(ovf_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    tick();
    tick();
    check("t5_no_stale", 32'(validrx), 32'h0);
    check("t5_dat_clear", 32'(dat_o), 32'h0);

    // Lane 2: ack stuck high holds the lane in release
    int_wen_i = 4'b0100;
    int_dat_i = 4'hB;
    tick();
    int_dat_i = 4'hC;
    tick();
    int_wen_i = '0;
    check("t6_datB", 32'(dat_o[11:8]), 32'hB);
    ackrx[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t6_hold", 32'(validrx[2]), 32'h0);
    end
    ackrx[2] = 1'b0;
    tick();
    check("t6_idle", 32'(validrx[2]), 32'h0);
    tick();
    check("t6_validC", 32'(validrx[2]), 32'h1);
    check("t6_datC", 32'(dat_o[11:8]), 32'hC);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
